// File: rtl/hb_decim_sequencer_if.sv
// Sample stream interface for the half-band decimator.
//   x_in    : signed input sample (18 bit)
//   x_valid : input strobe, x_in accepted on every edge where high
//   y       : signed decimated output (18 bit), holds between updates
//   y_valid : one-cycle pulse when y is updated
// master drives samples and observes results; slave is the decimator.
interface hb_decim_sequencer_if;
  logic signed [17:0] x_in;
  logic               x_valid;
  logic signed [17:0] y;
  logic               y_valid;

  modport master (output x_in, x_valid, input y, y_valid);
  modport slave  (input x_in, x_valid, output y, y_valid);
endinterface

// File: rtl/hb_decim_sequencer.sv
// Decimate-by-2 9-tap half-band filter sequencer. A single 18x18 signed
// multiplier is time-shared across the two symmetric coefficient pairs;
// the center tap (0.6875 * x[4]) is built from shifts.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   s        : sample stream (x_in/x_valid in, y/y_valid out)
//   clr_ovr  : synchronous clear of overrun
//   busy     : high while the sequencer is not IDLE
//   overrun  : sticky, a trigger arrived while the sequencer was mid-compute
//
// state | meaning
// IDLE  | waiting for a trigger (every 2nd accepted sample)
// LOAD  | snapshot pair sums and center tap from the delay line
// PAIR0 | acc = outer pair * COEF_A
// PAIR1 | acc += inner pair * COEF_B
// FINAL | y = acc + center-tap terms, pulse y_valid, may chain into LOAD
module hb_decim_sequencer #(
  parameter logic signed [17:0] COEF_A = -18'sd16941,
  parameter logic signed [17:0] COEF_B = 18'sd105834
) (
  input  logic                       clk,
  input  logic                       reset,
  hb_decim_sequencer_if.slave        s,
  input  logic                       clr_ovr,
  output logic                       busy,
  output logic                       overrun
);

  typedef enum logic [2:0] {IDLE, LOAD, PAIR0, PAIR1, FINAL} state_t;

  state_t             state;
  logic signed [17:0] dl [0:8];
  logic               phase;
  logic signed [17:0] s1, s2, c, acc;
  logic signed [17:0] mul_a, mul_b;
  logic signed [35:0] prod;
  logic signed [17:0] prod_hi;
  logic signed [17:0] c_sum;
  logic               trigger;
  logic               drop;

  assign trigger = s.x_valid & phase;
  assign drop    = trigger & ((state == LOAD) | (state == PAIR0) | (state == PAIR1));

  // Operand mux: inner pair only during PAIR1, outer pair otherwise.
  always_comb begin
    mul_a = s1;
    mul_b = COEF_A;
    if (state == PAIR1) begin
      mul_a = s2;
      mul_b = COEF_B;
    end
  end

  assign prod    = mul_a * mul_b;
  assign prod_hi = prod[35:18];
  assign c_sum   = (c >>> 1) + (c >>> 3) + (c >>> 4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) dl[i] <= '0;
      phase     <= 1'b0;
      state     <= IDLE;
      s1        <= '0;
      s2        <= '0;
      c         <= '0;
      acc       <= '0;
      s.y       <= '0;
      s.y_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      s.y_valid <= 1'b0;

      // Delay line and phase advance on every accepted sample, whatever the FSM is doing.
      if (s.x_valid) begin
        dl[0] <= {s.x_in[17], s.x_in[17:1]};
        for (int i = 1; i < 9; i++) dl[i] <= dl[i-1];
        phase <= ~phase;
      end

      if (drop)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (trigger) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          // Registers still hold the line as it was right after the trigger shift.
          s1    <= dl[1] + dl[7];
          s2    <= dl[3] + dl[5];
          c     <= dl[4];
          state <= PAIR0;
        end
        PAIR0: begin
          acc   <= prod_hi;
          state <= PAIR1;
        end
        PAIR1: begin
          acc   <= acc + prod_hi;
          state <= FINAL;
        end
        FINAL: begin
          s.y       <= acc + c_sum;
          s.y_valid <= 1'b1;
          if (trigger) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hb_decim_sequencer.sv
module tb_hb_decim_sequencer;

  localparam longint COEF_A = -16941;
  localparam longint COEF_B = 105834;

  logic clk;
  logic reset;
  logic clr_ovr;
  logic busy;
  logic overrun;

  hb_decim_sequencer_if bus ();

  hb_decim_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .s       (bus.slave),
    .clr_ovr (clr_ovr),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // reference model state
  int hist [0:8];
  int phase_m;
  int edge_n;
  int last_trig;
  int exp_y;
  int exp_yv;
  int exp_busy;
  int exp_ovr;
  int pend_edge [$];
  int pend_val  [$];
  int obs_y     [$];

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, expv, edge_n);
    end
  endtask

  function automatic int wrap18(input longint v);
    logic signed [17:0] t;
    t = v[17:0];
    return int'(t);
  endfunction

  // Half-band output from the halved sample history, hist[k] = k samples ago.
  function automatic int model_y();
    longint s1, s2, c, acc, p1, p2;
    s1  = wrap18(longint'(hist[1]) + longint'(hist[7]));
    s2  = wrap18(longint'(hist[3]) + longint'(hist[5]));
    c   = hist[4];
    p1  = (s1 * COEF_A) >>> 18;
    p2  = (s2 * COEF_B) >>> 18;
    acc = wrap18(p1);
    acc = wrap18(acc + wrap18(p2));
    return wrap18(acc + (c >>> 1) + (c >>> 3) + (c >>> 4));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) hist[k] = 0;
    phase_m   = 0;
    last_trig = -100;
    exp_y     = 0;
    exp_yv    = 0;
    exp_busy  = 0;
    exp_ovr   = 0;
    pend_edge.delete();
    pend_val.delete();
  endtask

  task automatic step(input bit xv, input logic signed [17:0] xi, input bit clr);
    bit drop;
    int d;
    bus.x_valid = xv;
    bus.x_in    = xi;
    clr_ovr     = clr;
    @(posedge clk);
    #1;
    edge_n++;
    exp_yv = 0;
    if (pend_edge.size() > 0 && pend_edge[0] == edge_n) begin
      void'(pend_edge.pop_front());
      exp_y  = pend_val.pop_front();
      exp_yv = 1;
    end
    drop = 1'b0;
    if (xv) begin
      for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(xi) >>> 1;
      if (phase_m == 1) begin
        d = edge_n - last_trig;
        if (d >= 1 && d <= 3) drop = 1'b1;
        else begin
          last_trig = edge_n;
          pend_edge.push_back(edge_n + 4);
          pend_val.push_back(model_y());
        end
      end
      phase_m = 1 - phase_m;
    end
    if (drop) exp_ovr = 1;
    else if (clr) exp_ovr = 0;
    d = edge_n - last_trig;
    exp_busy = (d >= 0 && d <= 3) ? 1 : 0;

    chk("y", int'(bus.y), exp_y);
    chk("y_valid", int'(bus.y_valid), exp_yv);
    chk("busy", int'(busy), exp_busy);
    chk("overrun", int'(overrun), exp_ovr);
    if (bus.y_valid) obs_y.push_back(int'(bus.y));
  endtask

  task automatic send2(input logic signed [17:0] xi);
    step(1'b1, xi, 1'b0);
    step(1'b0, 18'($urandom), 1'b0);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_y", int'(bus.y), 0);
    chk("rst_y_valid", int'(bus.y_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    model_reset();
    bus.x_valid = 1'b0;
    clr_ovr     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int pair_exp [5] = '{-133, 826, 826, -133, 0};
  int start_cnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    edge_n   = 0;
    model_reset();
    bus.x_valid = 1'b0;
    bus.x_in    = '0;
    clr_ovr     = 1'b0;
    reset       = 1'b0;
    #2;
    chk("init_y", int'(bus.y), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_overrun", int'(overrun), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // center impulse on 2nd sample
    send2(18'sd0);
    send2(18'sd4096);
    for (int i = 0; i < 8; i++) send2(18'sd0);
    flush(6);

    // pair impulse on 1st sample
    obs_y.delete();
    send2(18'sd4096);
    for (int i = 0; i < 9; i++) send2(18'sd0);
    flush(6);
    chk("pair_count", obs_y.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < obs_y.size()) chk($sformatf("pair_y%0d", i), obs_y[i], pair_exp[i]);

    // overrun: x_valid every cycle for 8 samples
    obs_y.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 18'($urandom), 1'b0);
    flush(8);
    chk("ovr_pulses", obs_y.size(), 2);
    chk("ovr_set", int'(overrun), 1);
    step(1'b0, '0, 1'b1);
    chk("ovr_clr", int'(overrun), 0);

    // back-to-back triggers every 4 cycles
    obs_y.delete();
    for (int i = 0; i < 20; i++) send2(18'($urandom));
    flush(6);
    chk("b2b_count", obs_y.size(), 10);

    // wrap: constant full-scale positive
    for (int i = 0; i < 20; i++) send2(18'sd131071);
    flush(6);
    for (int i = 0; i < 20; i++) send2(-18'sd131072);
    flush(6);

    // random traffic with a mid-stream reset
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) != 0, 18'($urandom), $urandom_range(0, 15) == 0);
    mid_reset();
    start_cnt = obs_y.size();
    send2(18'sd5000);
    flush(6);
    chk("post_rst_no_out", obs_y.size() - start_cnt, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 18'($urandom), $urandom_range(0, 15) == 0);
    flush(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
